// File: rtl/sparse_relu_layer_controller.sv
// Sparse ReLU hidden-layer controller: sums the weight rows selected by a queue of
// active pixel indices onto a bias, applies saturating ReLU, and holds the result.
module sparse_relu_layer_controller #(
    parameter int NODES        = 4,
    parameter int NUM_INPUTS   = 784,
    parameter int INDEX_WIDTH  = 10,
    parameter int WEIGHT_WIDTH = 4,
    parameter int ACC_WIDTH    = 16,
    parameter int OUT_WIDTH    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          inputsReady,
    input  logic                          queueEmpty,
    input  logic [INDEX_WIDTH-1:0]        queueOut,
    output logic                          dequeue,
    input  logic                          outputsRecieved,
    input  logic                          weightWriteEnable,
    input  logic                          biasWriteEnable,
    input  logic [INDEX_WIDTH-1:0]        WriteAddressSelect,
    input  logic [NODES*WEIGHT_WIDTH-1:0] writeIn,
    output logic                          outputsReady,
    output logic [NODES*OUT_WIDTH-1:0]    layer1Output,
    output logic                          busy,
    output logic                          indexError
);

    localparam int AW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [INDEX_WIDTH:0] ROW_LIMIT = (INDEX_WIDTH+1)'(NUM_INPUTS);
    localparam logic [OUT_WIDTH-1:0] OUT_MAX = '1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_INIT     = 3'd1;
    localparam logic [2:0] S_ISSUE    = 3'd2;
    localparam logic [2:0] S_READ     = 3'd3;
    localparam logic [2:0] S_ACCUM    = 3'd4;
    localparam logic [2:0] S_ACTIVATE = 3'd5;
    localparam logic [2:0] S_HOLD     = 3'd6;

    logic [2:0]                    state_q, state_d;
    logic                          pending_q, pending_d;
    logic                          index_err_q, index_err_d;
    logic [INDEX_WIDTH-1:0]        addr_q, addr_d;
    logic [NODES*WEIGHT_WIDTH-1:0] bias_q, bias_d;
    logic [NODES*OUT_WIDTH-1:0]    out_q, out_d;
    logic signed [ACC_WIDTH-1:0]   acc_q [NODES];
    logic signed [ACC_WIDTH-1:0]   acc_d [NODES];
    logic [NODES*WEIGHT_WIDTH-1:0] rdata_q;
    logic [NODES*WEIGHT_WIDTH-1:0] wmem_q [NUM_INPUTS];

    logic write_window;
    logic addr_ok;
    logic wr_addr_ok;

    function automatic logic signed [ACC_WIDTH-1:0] sext_w(input logic [WEIGHT_WIDTH-1:0] w);
        return {{(ACC_WIDTH-WEIGHT_WIDTH){w[WEIGHT_WIDTH-1]}}, w};
    endfunction

    function automatic logic [OUT_WIDTH-1:0] relu_sat(input logic signed [ACC_WIDTH-1:0] a);
        if (a[ACC_WIDTH-1]) return '0;
        if (|a[ACC_WIDTH-2:OUT_WIDTH]) return OUT_MAX;
        return a[OUT_WIDTH-1:0];
    endfunction

    assign write_window = (state_q == S_IDLE) || (state_q == S_HOLD);
    assign addr_ok      = ({1'b0, addr_q} < ROW_LIMIT);
    assign wr_addr_ok   = ({1'b0, WriteAddressSelect} < ROW_LIMIT);

    assign dequeue      = (state_q == S_ISSUE) && !queueEmpty;
    assign outputsReady = (state_q == S_HOLD);
    assign busy         = !write_window;
    assign indexError   = index_err_q;
    assign layer1Output = out_q;

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        index_err_d = index_err_q;
        addr_d      = addr_q;
        bias_d      = bias_q;
        out_d       = out_q;
        for (int i = 0; i < NODES; i++) acc_d[i] = acc_q[i];

        if (write_window && biasWriteEnable) bias_d = writeIn;

        // A request arriving while a frame is in flight or held is remembered once.
        if (inputsReady && (state_q != S_IDLE)
            && !((state_q == S_HOLD) && outputsRecieved)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (inputsReady) state_d = S_INIT;
            end
            S_INIT: begin
                for (int i = 0; i < NODES; i++)
                    acc_d[i] = sext_w(bias_q[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (queueEmpty) begin
                    state_d = S_ACTIVATE;
                end else begin
                    addr_d  = queueOut;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = S_ACCUM;
            end
            S_ACCUM: begin
                if (addr_ok) begin
                    for (int i = 0; i < NODES; i++)
                        acc_d[i] = acc_q[i] + sext_w(rdata_q[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
                end else begin
                    index_err_d = 1'b1;
                end
                state_d = S_ISSUE;
            end
            S_ACTIVATE: begin
                for (int i = 0; i < NODES; i++)
                    out_d[i*OUT_WIDTH +: OUT_WIDTH] = relu_sat(acc_q[i]);
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (outputsRecieved) begin
                    state_d   = (pending_q || inputsReady) ? S_INIT : S_IDLE;
                    pending_d = pending_q && inputsReady;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pending_q   <= 1'b0;
            index_err_q <= 1'b0;
            addr_q      <= '0;
            bias_q      <= '0;
            out_q       <= '0;
            for (int i = 0; i < NODES; i++) acc_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            index_err_q <= index_err_d;
            addr_q      <= addr_d;
            bias_q      <= bias_d;
            out_q       <= out_d;
            for (int i = 0; i < NODES; i++) acc_q[i] <= acc_d[i];
        end
    end

    // Weight RAM keeps its contents across reset; reads are registered for ACCUM.
    always_ff @(posedge clk) begin
        if (write_window && weightWriteEnable && wr_addr_ok)
            wmem_q[WriteAddressSelect[AW-1:0]] <= writeIn;
        if ((state_q == S_READ) && addr_ok)
            rdata_q <= wmem_q[addr_q[AW-1:0]];
    end

endmodule
